shift_mult_ctrl: RTL and testbench

SHIFT_MULT_CTRL -- requirements
Module: shift_mult_ctrl

---
 rtl/mult_pkg.sv | 18 +
 rtl/iter_counter.sv | 42 ++++
 rtl/shift_register.sv | 40 ++++
 rtl/shift_mult_ctrl.sv | 114 +++++++++++
 tb/tb_shift_mult_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequenced shift-add multiplier: FSM state encodings
// and a width helper used by the controller and its iteration counter.
package mult_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_ADD   = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // $clog2(1) is 0, so a counter for N=1 still needs one physical bit
    function automatic int safe_width(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the multiplier sequencer: clear has priority over
// increment, and last flags the final iteration (count == N-1).
module iter_counter
    import mult_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       inc_i,
    output logic [safe_width(CW)-1:0]  count_o,
    output logic                       last_o
);

    localparam int CWI = safe_width(CW);

    logic [CWI-1:0] count_q;
    logic [CWI-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CWI'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == CWI'(N - 1));

endmodule

// File: rtl/shift_register.sv
// Loadable right-shift register used for the A, B and P datapath registers.
// Priority: clear, then parallel load, then shift (serial input enters at the MSB).
module shift_register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic         sh_i,
    input  logic         ser_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d = d_i;
        end else if (sh_i) begin
            q_d = {ser_i, q_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/shift_mult_ctrl.sv
// Sequencer for an N-bit shift-add multiplier; drives external A/B/P registers.
//   state | meaning
//   IDLE  | waiting for start, all outputs low
//   LOAD  | load A and B, clear P, clear iteration counter
//   ADD   | add A into P when multiplier LSB is 1
//   SHIFT | shift {P,B} right, advance iteration counter
//   DONE  | one-cycle completion pulse
module shift_mult_ctrl
    import mult_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic lsb,
    output logic ldA,
    output logic ldB,
    output logic clrP,
    output logic ldP,
    output logic shR,
    output logic busy,
    output logic done
);

    localparam int CWI = safe_width(CW);

    state_t         state_q;
    state_t         state_d;
    logic           abort_act;
    logic           cnt_clr;
    logic           cnt_inc;
    logic           cnt_last;
    logic [CWI-1:0] iter_cnt_unused;

    assign abort_act = abort && (state_q != ST_IDLE);

    // Counter returns to zero on every exit path so a new operation never sees a stale count
    assign cnt_clr = (state_q == ST_LOAD) || abort_act ||
                     ((state_q == ST_SHIFT) && cnt_last);
    assign cnt_inc = (state_q == ST_SHIFT);

    iter_counter #(
        .N  (N),
        .CW (CW)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (iter_cnt_unused),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_act) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_ADD;
                ST_ADD:   state_d = ST_SHIFT;
                ST_SHIFT: state_d = cnt_last ? ST_DONE : ST_ADD;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ldA  = 1'b0;
        ldB  = 1'b0;
        clrP = 1'b0;
        ldP  = 1'b0;
        shR  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_LOAD: begin
                ldA  = 1'b1;
                ldB  = 1'b1;
                clrP = 1'b1;
                busy = 1'b1;
            end
            ST_ADD: begin
                ldP  = lsb;
                busy = 1'b1;
            end
            ST_SHIFT: begin
                shR  = 1'b1;
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Directed bench for shift_mult_ctrl: N=4 controller with driven lsb, N=1 corner case,
// and an N=8 controller wired to three shift_register instances.
module tb_shift_mult_ctrl;

    // output vector order: {ldA, ldB, clrP, ldP, shR, busy, done}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_LOAD  = 7'b1110010;
    localparam logic [6:0] O_ADD0  = 7'b0000010;
    localparam logic [6:0] O_ADD1  = 7'b0001010;
    localparam logic [6:0] O_SHIFT = 7'b0000110;
    localparam logic [6:0] O_DONE  = 7'b0000011;

    logic clk;
    logic rst;

    logic start4, abort4, lsb4;
    logic ldA4, ldB4, clrP4, ldP4, shR4, busy4, done4;
    logic start1, abort1, lsb1;
    logic ldA1, ldB1, clrP1, ldP1, shR1, busy1, done1;
    logic start8, abort8, lsb8;
    logic ldA8, ldB8, clrP8, ldP8, shR8, busy8, done8;
    logic [7:0] a_in, b_in, a_q, b_q;
    logic [8:0] p_q, p_sum;

    logic [6:0] out4, out1, out8;
    assign out4 = {ldA4, ldB4, clrP4, ldP4, shR4, busy4, done4};
    assign out1 = {ldA1, ldB1, clrP1, ldP1, shR1, busy1, done1};
    assign out8 = {ldA8, ldB8, clrP8, ldP8, shR8, busy8, done8};

    int checks = 0;
    int errors = 0;

    shift_mult_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4), .lsb(lsb4),
        .ldA(ldA4), .ldB(ldB4), .clrP(clrP4), .ldP(ldP4), .shR(shR4),
        .busy(busy4), .done(done4)
    );

    shift_mult_ctrl #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .lsb(lsb1),
        .ldA(ldA1), .ldB(ldB1), .clrP(clrP1), .ldP(ldP1), .shR(shR1),
        .busy(busy1), .done(done1)
    );

    shift_mult_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .lsb(lsb8),
        .ldA(ldA8), .ldB(ldB8), .clrP(clrP8), .ldP(ldP8), .shR(shR8),
        .busy(busy8), .done(done8)
    );

    assign p_sum = p_q + {1'b0, a_q};
    assign lsb8  = b_q[0];

    shift_register #(.W(8)) u_a (
        .clk(clk), .rst(rst), .clr_i(1'b0), .ld_i(ldA8), .sh_i(1'b0),
        .ser_i(1'b0), .d_i(a_in), .q_o(a_q)
    );

    shift_register #(.W(8)) u_b (
        .clk(clk), .rst(rst), .clr_i(1'b0), .ld_i(ldB8), .sh_i(shR8),
        .ser_i(p_q[0]), .d_i(b_in), .q_o(b_q)
    );

    shift_register #(.W(9)) u_p (
        .clk(clk), .rst(rst), .clr_i(clrP8), .ld_i(ldP8), .sh_i(shR8),
        .ser_i(1'b0), .d_i(p_sum), .q_o(p_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // expected outputs c cycles after the start edge, lsb held at 0
    function automatic logic [6:0] exp_vec(input int c, input int n);
        if (c == 1) return O_LOAD;
        if (c >= 2 && c <= 2 * n + 1) return (c % 2 == 0) ? O_ADD0 : O_SHIFT;
        if (c == 2 * n + 2) return O_DONE;
        return O_IDLE;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start4 = 0; abort4 = 0; lsb4 = 0;
        start1 = 0; abort1 = 0; lsb1 = 0;
        start8 = 0; abort8 = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        start4 = 0; abort4 = 0; lsb4 = 0;
        start1 = 0; abort1 = 0; lsb1 = 0;
        start8 = 0; abort8 = 0; a_in = 0; b_in = 0;
        rst = 0;
        #2 rst = 1;
        #2;
        checks++;
        if (out4 !== O_IDLE) begin
            errors++; $display("FAIL reset_async_n4 got=%b exp=%b", out4, O_IDLE);
        end
        checks++;
        if (out1 !== O_IDLE || out8 !== O_IDLE) begin
            errors++; $display("FAIL reset_async_n1_n8 got=%b/%b exp=%b", out1, out8, O_IDLE);
        end
        start4 = 1;
        tick();
        checks++;
        if (out4 !== O_IDLE) begin
            errors++; $display("FAIL reset_holds_idle got=%b exp=%b", out4, O_IDLE);
        end
        start4 = 0;
        tick();
        rst = 0;
        tick();
        checks++;
        if (out4 !== O_IDLE) begin
            errors++; $display("FAIL idle_after_release got=%b exp=%b", out4, O_IDLE);
        end
    endtask

    task automatic test_basic();
        logic [3:0]  lsb_seq;
        logic [6:0]  exp_add [4];
        lsb_seq = 4'b1101;
        exp_add = '{O_ADD1, O_ADD0, O_ADD1, O_ADD1};
        start4 = 1;
        tick();
        start4 = 0;
        checks++;
        if (out4 !== O_LOAD) begin
            errors++; $display("FAIL basic_load got=%b exp=%b", out4, O_LOAD);
        end
        for (int k = 0; k < 4; k++) begin
            lsb4 = lsb_seq[k];
            tick();
            checks++;
            if (out4 !== exp_add[k]) begin
                errors++; $display("FAIL basic_add k=%0d got=%b exp=%b", k, out4, exp_add[k]);
            end
            tick();
            checks++;
            if (out4 !== O_SHIFT) begin
                errors++; $display("FAIL basic_shift k=%0d got=%b exp=%b", k, out4, O_SHIFT);
            end
        end
        tick();
        checks++;
        if (out4 !== O_DONE) begin
            errors++; $display("FAIL basic_done_edge9 got=%b exp=%b", out4, O_DONE);
        end
        tick();
        checks++;
        if (out4 !== O_IDLE) begin
            errors++; $display("FAIL basic_back_idle got=%b exp=%b", out4, O_IDLE);
        end
        lsb4 = 0;
    endtask

    task automatic test_start_ignored();
        int dones;
        dones = 0;
        start4 = 1;
        tick();
        start4 = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) tick();
            if (done4 === 1'b1) dones++;
            checks++;
            if (out4 !== exp_vec(c, 4)) begin
                errors++; $display("FAIL ignore_start c=%0d got=%b exp=%b", c, out4, exp_vec(c, 4));
            end
            start4 = (c == 7);
        end
        start4 = 0;
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL ignore_start_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_abort();
        do_reset();
        start4 = 1;
        tick();
        start4 = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            checks++;
            if (out4 !== exp_vec(c, 4)) begin
                errors++; $display("FAIL abort_pre c=%0d got=%b exp=%b", c, out4, exp_vec(c, 4));
            end
        end
        abort4 = 1;
        tick();
        abort4 = 0;
        checks++;
        if (out4 !== O_IDLE) begin
            errors++; $display("FAIL abort_to_idle got=%b exp=%b", out4, O_IDLE);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out4 !== O_IDLE) begin
                errors++; $display("FAIL abort_stays_idle c=%0d got=%b exp=%b", c, out4, O_IDLE);
            end
        end
        start4 = 1;
        tick();
        start4 = 0;
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) tick();
            checks++;
            if (out4 !== exp_vec(c, 4)) begin
                errors++; $display("FAIL abort_restart c=%0d got=%b exp=%b", c, out4, exp_vec(c, 4));
            end
        end
        start4 = 1;
        abort4 = 1;
        tick();
        start4 = 0;
        abort4 = 0;
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) tick();
            checks++;
            if (out4 !== exp_vec(c, 4)) begin
                errors++; $display("FAIL abort_in_idle c=%0d got=%b exp=%b", c, out4, exp_vec(c, 4));
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [6:0] exp;
        do_reset();
        start4 = 1;
        tick();
        start4 = 0;
        for (int c = 2; c <= 5; c++) tick();
        checks++;
        if (out4 !== O_SHIFT) begin
            errors++; $display("FAIL rst_mid_pre got=%b exp=%b", out4, O_SHIFT);
        end
        start4 = 1;
        #2 rst = 1;
        #1;
        checks++;
        if (out4 !== O_IDLE) begin
            errors++; $display("FAIL rst_mid_async got=%b exp=%b", out4, O_IDLE);
        end
        tick();
        checks++;
        if (out4 !== O_IDLE) begin
            errors++; $display("FAIL rst_mid_held got=%b exp=%b", out4, O_IDLE);
        end
        #2 rst = 0;
        for (int c = 1; c <= 22; c++) begin
            tick();
            exp = (c <= 11) ? exp_vec(c, 4) : exp_vec(c - 11, 4);
            checks++;
            if (out4 !== exp) begin
                errors++; $display("FAIL rst_b2b c=%0d got=%b exp=%b", c, out4, exp);
            end
            if (c == 12) start4 = 0;
        end
    endtask

    task automatic test_n1();
        do_reset();
        start1 = 1;
        tick();
        start1 = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            checks++;
            if (out1 !== exp_vec(c, 1)) begin
                errors++; $display("FAIL n1_seq c=%0d got=%b exp=%b", c, out1, exp_vec(c, 1));
            end
        end
    endtask

    task automatic test_integration();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] vp [3];
        int c;
        va = '{8'd13, 8'd255, 8'd200};
        vb = '{8'd11, 8'd255, 8'd3};
        vp = '{16'd143, 16'd65025, 16'd600};
        do_reset();
        for (int v = 0; v < 3; v++) begin
            a_in = va[v];
            b_in = vb[v];
            start8 = 1;
            tick();
            start8 = 0;
            c = 1;
            while (done8 !== 1'b1 && c < 40) begin
                tick();
                c++;
            end
            checks++;
            if (done8 !== 1'b1) begin
                errors++; $display("FAIL int_timeout v=%0d got=no_done exp=done", v);
            end else begin
                checks++;
                if (c != 18) begin
                    errors++; $display("FAIL int_latency v=%0d got=%0d exp=18", v, c);
                end
                checks++;
                if ({p_q, b_q} !== {1'b0, vp[v]}) begin
                    errors++; $display("FAIL int_product v=%0d got=%0d exp=%0d", v, {p_q, b_q}, vp[v]);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_abort();
        test_reset_midop();
        test_n1();
        test_integration();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
